// File: rtl/riscv_test_ctrl.sv
// Run controller for RV32I core bring-up: sequences core reset, counts cycles and
// retired instructions per hart, and ends the run on TOHOST termination or cycle budget.
//
// state   | meaning
// IDLE    | waiting for i_start, cores held in reset
// RESET   | cores held in reset for RST_CYCLES cycles
// RUN     | cores released, counters active, watching TOHOST writes
// DONE    | run finished, results and counters frozen
module riscv_test_ctrl #(
   parameter int          N_HART      = 1,
   parameter int          RST_CYCLES  = 4,
   parameter int          MAX_CYCLES  = 200,
   parameter int          CNT_BIT     = 32,
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic [N_HART-1:0]           i_dmem_wr_en,
   input  logic [32*N_HART-1:0]        i_dmem_addr,
   input  logic [32*N_HART-1:0]        i_dmem_wdata,
   input  logic [N_HART-1:0]           i_retire,
   output logic                        o_core_rstn,
   output logic                        o_running,
   output logic                        o_done,
   output logic                        o_pass,
   output logic                        o_timeout,
   output logic [30:0]                 o_fail_code,
   output logic [N_HART-1:0]           o_hart_done,
   output logic [CNT_BIT-1:0]          o_cycle_cnt,
   output logic [CNT_BIT*N_HART-1:0]   o_instret
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RESET = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int                 RW         = $clog2(RST_CYCLES + 1);
   localparam logic [RW-1:0]      RST_LOAD   = RW'(RST_CYCLES - 1);
   localparam logic [CNT_BIT-1:0] MAX_M1     = CNT_BIT'(MAX_CYCLES - 1);
   localparam logic               TIMEOUT_EN = (MAX_CYCLES != 0);

   logic [1:0]                        state_q, state_d;
   logic [RW-1:0]                     rst_cnt_q, rst_cnt_d;
   logic [CNT_BIT-1:0]                cyc_q, cyc_d;
   logic [N_HART-1:0][CNT_BIT-1:0]    instret_q, instret_d;
   logic [N_HART-1:0]                 hart_done_q, hart_done_d;
   logic [N_HART-1:0]                 hart_fail_q, hart_fail_d;
   logic                              fail_seen_q, fail_seen_d;
   logic [30:0]                       fail_code_q, fail_code_d;
   logic                              timeout_q, timeout_d;

   logic [N_HART-1:0]                 term;
   logic [N_HART-1:0]                 bad;
   logic [30:0]                       first_code;
   logic                              all_done;

   // A termination is the first odd TOHOST write from a hart still running.
   always_comb begin
      term       = '0;
      bad        = '0;
      first_code = '0;
      for (int h = 0; h < N_HART; h++) begin
         if (state_q == S_RUN && !hart_done_q[h] && i_dmem_wr_en[h] &&
             i_dmem_addr[32*h +: 32] == TOHOST_ADDR && i_dmem_wdata[32*h]) begin
            term[h] = 1'b1;
            bad[h]  = (i_dmem_wdata[32*h +: 32] != 32'd1);
         end
      end
      // descending scan so the lowest failing index is written last
      for (int h = N_HART - 1; h >= 0; h--) begin
         if (bad[h]) first_code = i_dmem_wdata[32*h+1 +: 31];
      end
   end

   assign all_done = &(hart_done_q | term);

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      cyc_d       = cyc_q;
      instret_d   = instret_q;
      hart_done_d = hart_done_q;
      hart_fail_d = hart_fail_q;
      fail_seen_d = fail_seen_q;
      fail_code_d = fail_code_q;
      timeout_d   = timeout_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               state_d     = S_RESET;
               rst_cnt_d   = RST_LOAD;
               cyc_d       = '0;
               instret_d   = '0;
               hart_done_d = '0;
               hart_fail_d = '0;
               fail_seen_d = 1'b0;
               fail_code_d = '0;
               timeout_d   = 1'b0;
            end
         end
         S_RESET: begin
            if (rst_cnt_q == '0) state_d = S_RUN;
            else                 rst_cnt_d = rst_cnt_q - RW'(1);
         end
         S_RUN: begin
            hart_done_d = hart_done_q | term;
            hart_fail_d = hart_fail_q | bad;
            if (!fail_seen_q && |bad) begin
               fail_seen_d = 1'b1;
               fail_code_d = first_code;
            end
            for (int h = 0; h < N_HART; h++) begin
               if (i_retire[h] && !hart_done_q[h]) instret_d[h] = instret_q[h] + CNT_BIT'(1);
            end
            // completion outranks the budget, and the cycle count freezes on exit
            if (all_done) begin
               state_d = S_DONE;
            end else if (TIMEOUT_EN && cyc_q == MAX_M1) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else begin
               cyc_d = cyc_q + CNT_BIT'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         cyc_q       <= '0;
         instret_q   <= '0;
         hart_done_q <= '0;
         hart_fail_q <= '0;
         fail_seen_q <= 1'b0;
         fail_code_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         cyc_q       <= cyc_d;
         instret_q   <= instret_d;
         hart_done_q <= hart_done_d;
         hart_fail_q <= hart_fail_d;
         fail_seen_q <= fail_seen_d;
         fail_code_q <= fail_code_d;
         timeout_q   <= timeout_d;
      end
   end

   assign o_core_rstn = (state_q == S_RUN) || (state_q == S_DONE);
   assign o_running   = (state_q == S_RUN);
   assign o_done      = (state_q == S_DONE);
   assign o_pass      = (state_q == S_DONE) && !timeout_q && !(|hart_fail_q);
   assign o_timeout   = timeout_q;
   assign o_fail_code = fail_code_q;
   assign o_hart_done = hart_done_q;
   assign o_cycle_cnt = cyc_q;
   assign o_instret   = instret_q;

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Bench for riscv_test_ctrl: per-run stimulus plans, a run-level reference model
// feeding a scoreboard queue, and a monitor that checks each completed run.
module tb_riscv_test_ctrl;

   localparam int          NH     = 2;
   localparam int          RSTC   = 4;
   localparam int          MAXC   = 200;
   localparam int          NC     = 256;
   localparam logic [31:0] TOHOST = 32'h0000_1000;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_start = 1'b0;
   logic [NH-1:0]     i_dmem_wr_en = '0;
   logic [32*NH-1:0]  i_dmem_addr = '0;
   logic [32*NH-1:0]  i_dmem_wdata = '0;
   logic [NH-1:0]     i_retire = '0;
   logic              o_core_rstn, o_running, o_done, o_pass, o_timeout;
   logic [30:0]       o_fail_code;
   logic [NH-1:0]     o_hart_done;
   logic [31:0]       o_cycle_cnt;
   logic [32*NH-1:0]  o_instret;

   riscv_test_ctrl #(.N_HART(NH), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
                     .CNT_BIT(32), .TOHOST_ADDR(TOHOST)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
      .i_dmem_wr_en(i_dmem_wr_en), .i_dmem_addr(i_dmem_addr),
      .i_dmem_wdata(i_dmem_wdata), .i_retire(i_retire),
      .o_core_rstn(o_core_rstn), .o_running(o_running), .o_done(o_done),
      .o_pass(o_pass), .o_timeout(o_timeout), .o_fail_code(o_fail_code),
      .o_hart_done(o_hart_done), .o_cycle_cnt(o_cycle_cnt), .o_instret(o_instret));

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        pass;
      logic        timeout;
      logic [30:0] fail_code;
      logic [1:0]  hart_done;
      logic [31:0] cyc;
      logic [31:0] ir0;
      logic [31:0] ir1;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // stimulus plan for one run, indexed by RUN cycle
   logic        pw_en   [NH][NC];
   logic [31:0] pw_addr [NH][NC];
   logic [31:0] pw_data [NH][NC];
   logic        pr      [NH][NC];
   logic        pst     [NC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_plan();
      for (int h = 0; h < NH; h++)
         for (int c = 0; c < NC; c++) begin
            pw_en[h][c] = 1'b0; pw_addr[h][c] = '0; pw_data[h][c] = '0; pr[h][c] = 1'b0;
         end
      for (int c = 0; c < NC; c++) pst[c] = 1'b0;
   endtask

   task automatic set_wr(input int h, input int c, input logic [31:0] a, input logic [31:0] d);
      pw_en[h][c] = 1'b1; pw_addr[h][c] = a; pw_data[h][c] = d;
   endtask

   // Run-level outcome from the plan: find each hart's terminating cycle, then derive the result.
   function automatic exp_t model();
      exp_t e;
      int   t[NH];
      int   last, fin, best_t, lim;
      logic all, tmo, anyfail;
      logic [31:0] cnt[NH];
      all = 1'b1; last = 0;
      for (int h = 0; h < NH; h++) begin
         t[h] = -1;
         for (int c = 0; c < NC; c++)
            if (t[h] < 0 && pw_en[h][c] && pw_addr[h][c] == TOHOST && pw_data[h][c][0]) t[h] = c;
         if (t[h] < 0) all = 1'b0;
         else if (t[h] > last) last = t[h];
      end
      if (all && last <= MAXC - 1) begin fin = last; tmo = 1'b0; end
      else begin fin = MAXC - 1; tmo = 1'b1; end
      e.fail_code = '0; e.hart_done = '0; best_t = NC + 1; anyfail = 1'b0;
      for (int h = 0; h < NH; h++) begin
         if (t[h] >= 0 && t[h] <= fin) begin
            e.hart_done[h] = 1'b1;
            if (pw_data[h][t[h]] != 32'd1) begin
               anyfail = 1'b1;
               if (t[h] < best_t) begin best_t = t[h]; e.fail_code = pw_data[h][t[h]][31:1]; end
            end
         end
         lim = (t[h] >= 0 && t[h] < fin) ? t[h] : fin;
         cnt[h] = 0;
         for (int c = 0; c <= lim; c++) if (pr[h][c]) cnt[h]++;
      end
      e.timeout = tmo;
      e.pass    = !tmo && !anyfail;
      e.cyc     = fin;
      e.ir0     = cnt[0];
      e.ir1     = cnt[1];
      return e;
   endfunction

   task automatic drive_cycle(input int c);
      i_start = pst[c];
      for (int h = 0; h < NH; h++) begin
         i_dmem_wr_en[h]          = pw_en[h][c];
         i_dmem_addr[32*h +: 32]  = pw_addr[h][c];
         i_dmem_wdata[32*h +: 32] = pw_data[h][c];
         i_retire[h]              = pr[h][c];
      end
   endtask

   task automatic idle_inputs();
      i_start = 1'b0; i_dmem_wr_en = '0; i_dmem_addr = '0; i_dmem_wdata = '0; i_retire = '0;
   endtask

   // Pulse start, check reset length and cleared counters, wait for RUN.
   task automatic start_run(output logic ok);
      int lows, k;
      @(negedge i_clk); i_start = 1'b1;
      @(negedge i_clk); i_start = 1'b0;
      lows = 0;
      for (k = 0; k < 20 && !o_running; k++) begin
         if (!o_core_rstn) lows++;
         @(negedge i_clk);
      end
      ok = o_running;
      chk("reach_run", {63'd0, o_running}, 64'd1);
      chk("rstn_low_cycles", lows, RSTC);
      chk("first_run_cycle_cnt", o_cycle_cnt, 0);
      chk("run_entry_cleared", {o_hart_done, o_instret, o_done, o_timeout}, 0);
   endtask

   task automatic do_run();
      exp_t e;
      logic ok;
      int   c;
      e = model();
      sb.push_back(e);
      start_run(ok);
      c = 0;
      if (ok) begin
         while (c < NC && !o_done) begin
            drive_cycle(c);
            @(negedge i_clk);
            c++;
         end
      end
      idle_inputs();
      if (!o_done) begin
         checks++; errors++;
         $display("FAIL run_done_bound actual=not_done required=done");
         void'(sb.pop_back());
      end
      repeat (5) @(negedge i_clk);
      chk("frozen_cycle_cnt", o_cycle_cnt, e.cyc);
      chk("done_held", {63'd0, o_done}, 64'd1);
   endtask

   // monitor: each completed run is compared against the oldest expectation
   logic done_prev = 1'b0;
   always @(negedge i_clk) begin
      if (o_done && !done_prev) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=done required=no_pending_run");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pass",      {63'd0, o_pass},    {63'd0, e.pass});
            chk("timeout",   {63'd0, o_timeout}, {63'd0, e.timeout});
            chk("fail_code", {33'd0, o_fail_code}, {33'd0, e.fail_code});
            chk("hart_done", {62'd0, o_hart_done}, {62'd0, e.hart_done});
            chk("cycle_cnt", {32'd0, o_cycle_cnt}, {32'd0, e.cyc});
            chk("instret0",  {32'd0, o_instret[31:0]},  {32'd0, e.ir0});
            chk("instret1",  {32'd0, o_instret[63:32]}, {32'd0, e.ir1});
            chk("running_low_at_done", {63'd0, o_running}, 64'd0);
         end
      end
      done_prev = o_done;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   function automatic int all_out_ones();
      return $countones({o_core_rstn, o_running, o_done, o_pass, o_timeout, o_fail_code,
                         o_hart_done, o_cycle_cnt, o_instret});
   endfunction

   initial begin
      logic ok;
      int   p;
      idle_inputs();
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("reset_outputs_zero", all_out_ones(), 0);
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("idle_rstn_low", {63'd0, o_core_rstn}, 64'd0);

      // both harts pass, last at cycle 20; stray start mid-run is ignored
      clear_plan();
      set_wr(1, 10, TOHOST, 32'd1);
      set_wr(0, 20, TOHOST, 32'd1);
      pst[7] = 1'b1;
      for (int c = 0; c < 25; c++) pr[0][c] = 1'b1;
      do_run();

      // hart1 passes at 5, hart0 fails with 7 at 9, later write ignored
      clear_plan();
      set_wr(1, 5, TOHOST, 32'd1);
      set_wr(0, 9, TOHOST, 32'h0000_0007);
      set_wr(0, 12, TOHOST, 32'd1);
      do_run();

      // no termination at all: budget expires
      clear_plan();
      for (int c = 0; c < NC; c += 3) pr[1][c] = 1'b1;
      do_run();

      // last hart terminates exactly on the final budget cycle
      clear_plan();
      set_wr(1, 50, TOHOST, 32'd1);
      set_wr(0, MAXC - 1, TOHOST, 32'd1);
      do_run();

      // one cycle too late: timeout with only hart1 done
      clear_plan();
      set_wr(1, 50, TOHOST, 32'd1);
      set_wr(0, MAXC, TOHOST, 32'd1);
      do_run();

      // retire 15 pulses with 3 after termination; even and off-address writes ignored
      clear_plan();
      for (int c = 0; c < 12; c++) pr[0][c] = 1'b1;
      for (int c = 31; c < 34; c++) pr[0][c] = 1'b1;
      set_wr(0, 3, TOHOST, 32'd2);
      set_wr(0, 4, TOHOST + 32'd4, 32'd1);
      set_wr(0, 30, TOHOST, 32'd1);
      set_wr(1, 2, TOHOST, 32'd1);
      do_run();

      // same-cycle failures from both harts: lowest index code wins
      clear_plan();
      set_wr(0, 15, TOHOST, 32'h0000_0021);
      set_wr(1, 15, TOHOST, 32'h0000_0033);
      do_run();

      // randomized runs
      for (int r = 0; r < 12; r++) begin
         clear_plan();
         p = $urandom_range(8, 160);
         for (int h = 0; h < NH; h++)
            for (int c = 0; c < NC; c++) begin
               pr[h][c] = ($urandom_range(0, 1) == 1);
               if ($urandom_range(1, p) == 1) begin
                  logic [31:0] a, d;
                  case ($urandom_range(0, 3))
                     0, 1:    a = TOHOST;
                     2:       a = TOHOST + 32'd4;
                     default: a = $urandom;
                  endcase
                  case ($urandom_range(0, 3))
                     0, 3:    d = 32'd1;
                     1:       d = $urandom | 32'd1;
                     default: d = $urandom & ~32'd1;
                  endcase
                  set_wr(h, c, a, d);
               end
            end
         for (int c = 0; c < NC; c++) pst[c] = ($urandom_range(0, 15) == 0);
         do_run();
      end

      // reset asserted in the middle of a run
      clear_plan();
      start_run(ok);
      for (int c = 0; c < 10; c++) begin
         i_retire = 2'b11;
         @(negedge i_clk);
      end
      idle_inputs();
      i_rst = 1'b1;
      i_start = 1'b1;
      @(negedge i_clk);
      chk("midrun_reset_outputs_zero", all_out_ones(), 0);
      i_rst = 1'b0;
      i_start = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("midrun_reset_stays_idle", {o_core_rstn, o_running, o_done}, 0);

      // fresh run after the mid-run reset
      clear_plan();
      set_wr(0, 8, TOHOST, 32'd1);
      set_wr(1, 11, TOHOST, 32'd1);
      for (int c = 0; c < 20; c++) pr[1][c] = 1'b1;
      do_run();

      repeat (3) @(negedge i_clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_test_ctrl.md
# riscv_test_ctrl

Synthesisable run controller for the RV32I pipeline bench and FPGA bring-up. It sequences core reset for a parametrised number of cycles and counts cycles and retired instructions per hart. It ends the run when every hart writes a termination word to the TOHOST address, or when a cycle budget expires. It then reports pass, fail or timeout, which replaces fixed-length simulation with a self-terminating, self-checking run across N_HART cores.

## Interface
- N_HART, 1: number of monitored cores (1..8)
- RST_CYCLES, 4: cycles o_core_rstn is held low after start (>=1)
- MAX_CYCLES, 200: RUN cycle budget; 0 disables timeout
- CNT_BIT, 32: width of cycle and instret counters
- TOHOST_ADDR, 32'h0000_1000: byte address of termination word

- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start/restart request, sampled in IDLE and DONE
- i_dmem_wr_en  in  N_HART  per-hart data-memory write strobe
- i_dmem_addr  in  32*N_HART  per-hart write byte address, hart h at [32h+31:32h]
- i_dmem_wdata  in  32*N_HART  per-hart write data
- i_retire  in  N_HART  per-hart instruction-retired pulse
- o_core_rstn  out  1  active-low reset to cores
- o_running  out  1  high in RUN
- o_done  out  1  run finished (held)
- o_pass  out  1  all harts passed, no timeout (valid with o_done)
- o_timeout  out  1  budget expired
- o_fail_code  out  31  tohost[31:1] of first failing hart
- o_hart_done  out  N_HART  per-hart termination seen
- o_cycle_cnt  out  CNT_BIT  RUN cycles elapsed
- o_instret  out  CNT_BIT*N_HART  per-hart retired count

## Operation
- States: IDLE, RESET, RUN, DONE. i_rst forces IDLE from any state, including mid-run.
- On i_rst, all outputs are 0, including o_core_rstn, and all counters clear.
- IDLE: o_core_rstn=0. i_start=1 moves to RESET and loads the reset counter.
- RESET: o_core_rstn=0 for exactly RST_CYCLES cycles, then RUN.
  - Cycle and instret counters and all sticky flags clear on entry.
- RUN: o_core_rstn=1, o_running=1. o_cycle_cnt increments every cycle.
  - o_instret[h] increments on i_retire[h] while o_hart_done[h]=0.
- Termination write: hart h sets o_hart_done[h] when i_dmem_wr_en[h]=1, addr==TOHOST_ADDR and wdata[0]=1.
  - wdata==1 marks a pass. Any other odd value marks a fail.
  - Writes with wdata[0]=0 to TOHOST are ignored.
  - Further writes from a hart that is already done are ignored.
- o_fail_code latches the wdata[31:1] of the first failing hart. The lowest index wins on the same cycle. Later failures do not overwrite it.
- RUN exits to DONE when all o_hart_done are set. This takes priority over timeout on the same cycle.
- If MAX_CYCLES!=0 and o_cycle_cnt==MAX_CYCLES-1 with harts still pending, the next state is DONE and o_timeout=1.
- DONE: o_done=1. o_pass is set only when every hart passed and o_timeout=0.
  - Counters and flags freeze. o_core_rstn stays 1 so core state remains observable.
  - i_start=1 re-enters RESET.
- Counters wrap modulo 2^CNT_BIT; there is no saturation.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Start latency: i_start high at edge k gives o_core_rstn=0 from k+1 through k+RST_CYCLES.
  - o_core_rstn=1 and o_running=1 from edge k+RST_CYCLES+1.
- o_cycle_cnt reads 0 in the first RUN cycle.
- Termination: the last completing write sampled at edge t gives o_hart_done for that hart, o_done and o_pass all visible after edge t+1. o_running is low after that edge.
- Timeout: o_done and o_timeout rise one edge after the cycle in which o_cycle_cnt==MAX_CYCLES-1. o_cycle_cnt freezes at MAX_CYCLES-1.
- i_start in RESET or RUN is ignored.
- i_rst at any edge outranks i_start and any termination on the same edge.

## Test plan
- N_HART=1, RST_CYCLES=4: pulse i_start, then drive TOHOST write wdata=1 at RUN cycle 20.
  - Required: o_core_rstn low exactly 4 cycles; o_done=1, o_pass=1, o_cycle_cnt=20.
- N_HART=2: hart1 writes 1 at cycle 5; hart0 writes 0x0000_0007 at cycle 9; hart0 writes again at cycle 12.
  - Required: o_done after cycle 9; o_pass=0; o_fail_code=3; o_hart_done=2'b11 at cycle 5/9; the cycle-12 write is ignored.
- MAX_CYCLES=200 with no TOHOST write.
  - Required: o_timeout=1, o_done=1, o_pass=0, o_cycle_cnt=199.
- Last hart terminates on the same cycle the count hits MAX_CYCLES-1.
  - Required: o_timeout=0, o_pass=1.
- Pulse i_retire 15 times, including 3 times after that hart is done.
  - Required: o_instret=12.
  - Additionally: TOHOST write with wdata=2 is ignored; a write to TOHOST_ADDR+4 is ignored.
- Assert i_rst mid-RUN.
  - Required: next cycle all outputs 0 and state IDLE.
  - Additionally: i_start from DONE restarts with cleared counters.
